// File: rtl/data_cache_if.sv
// Core-side request/response and backing-memory bus of the data cache.
// slave is the cache's view; master is the core plus memory environment.
interface data_cache_if;
  logic        core_enabled_i;
  logic [29:0] core_address_i;
  logic [3:0]  core_write_en_i;
  logic [31:0] core_data_i;
  logic [31:0] core_data_o;
  logic        core_blocking_n_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  core_enabled_i, core_address_i, core_write_en_i, core_data_i,
    output core_data_o, core_blocking_n_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output core_enabled_i, core_address_i, core_write_en_i, core_data_i,
    input  core_data_o, core_blocking_n_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache
// with zero-latency load hits and load hit/miss counters.
module data_cache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_cache_if.slave       bus,
  input  logic              invalidate_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_MISS = 2'd1;
  localparam logic [1:0] S_WR_THRU = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [31:0]      r_ldata;
  logic [31:0]      r_hits;
  logic [31:0]      r_misses;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_idle;
  logic             w_busy;
  logic             w_store;
  logic             w_load;
  logic             w_inv;
  logic             w_hit;

  assign w_idx   = bus.core_address_i[IDX_W-1:0];
  assign w_tag   = bus.core_address_i[29:IDX_W];
  assign w_idle  = (r_state == S_IDLE);
  assign w_busy  = (r_state == S_RD_MISS) || (r_state == S_WR_THRU);
  assign w_store = |bus.core_write_en_i;
  assign w_load  = bus.core_enabled_i && !w_store;
  assign w_inv   = invalidate_i && w_idle;
  // A load arriving together with an invalidate must see the line as gone.
  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !w_inv;

  assign bus.core_blocking_n_o = !rst_i ||
      !(w_busy || (w_idle && bus.core_enabled_i && (w_store || !w_hit)));
  assign bus.core_data_o = (w_idle && w_load && w_hit) ? r_data[w_idx] : r_ldata;

  assign bus.mem_req_o   = w_busy;
  assign bus.mem_we_o    = (r_state == S_WR_THRU);
  assign bus.mem_addr_o  = bus.core_address_i;
  assign bus.mem_wdata_o = bus.core_data_i;
  assign bus.mem_wstrb_o = (r_state == S_WR_THRU) ? bus.core_write_en_i : '0;

  assign hit_count_o  = r_hits;
  assign miss_count_o = r_misses;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_ldata  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_inv) r_valid <= '0;
          if (bus.core_enabled_i) begin
            if (w_store) begin
              r_state <= S_WR_THRU;
            end else if (w_hit) begin
              r_hits <= r_hits + 32'd1;
            end else begin
              r_misses <= r_misses + 32'd1;
              r_state  <= S_RD_MISS;
            end
          end
        end
        S_RD_MISS: begin
          if (bus.mem_ack_i) begin
            r_valid[w_idx] <= 1'b1;
            r_ldata        <= bus.mem_rdata_i;
            r_state        <= S_DONE;
          end
        end
        S_WR_THRU: begin
          if (bus.mem_ack_i) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line payload carries no reset; only the valid bits gate its use.
  always_ff @(posedge clk_i) begin
    if ((r_state == S_RD_MISS) && bus.mem_ack_i) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= bus.mem_rdata_i;
    end else if ((r_state == S_WR_THRU) && bus.mem_ack_i && w_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.core_write_en_i[b]) r_data[w_idx][8*b +: 8] <= bus.core_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a scripted backing memory.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inv = 1'b0;
  logic [31:0] hits;
  logic [31:0] misses;

  data_cache_if bus();

  data_cache #(.LINES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .bus          (bus.slave),
    .invalidate_i (inv),
    .hit_count_o  (hits),
    .miss_count_o (misses)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          low, mc;
  logic [31:0] rd;
  logic        sw, tmo;
  logic [3:0]  ss;
  logic [29:0] sa;

  // One core access; memory acks on the ackd-th cycle of mem_req_o.
  // invmode: 0 none, 1 invalidate in the request cycle, 2 invalidate during the memory phase.
  task automatic access(input logic [29:0] a, input logic [3:0] s, input logic [31:0] wd,
                        input logic [31:0] md, input int ackd, input int invmode,
                        output int lowc, output int memc, output logic [31:0] rdat,
                        output logic swe, output logic [3:0] sstrb, output logic [29:0] saddr,
                        output logic timeout);
    bus.core_enabled_i  = 1'b1;
    bus.core_address_i  = a;
    bus.core_write_en_i = s;
    bus.core_data_i     = wd;
    lowc = 0; memc = 0; rdat = '0; swe = 1'b0; sstrb = '0; saddr = '0; timeout = 1'b1;
    inv = (invmode == 1);
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.core_blocking_n_o) begin
        rdat = bus.core_data_o;
        timeout = 1'b0;
        break;
      end
      lowc++;
      if (bus.mem_req_o) begin
        memc++;
        swe = bus.mem_we_o; sstrb = bus.mem_wstrb_o; saddr = bus.mem_addr_o;
        inv = (invmode == 2);
        if (memc == ackd) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = md;
        end
      end
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      inv = 1'b0;
    end
    @(posedge clk); #1;
    bus.core_enabled_i  = 1'b0;
    bus.core_write_en_i = '0;
    inv = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.core_blocking_n_o !== 1'b1) begin errors++; $display("FAIL rst_blocking got %b exp 1", bus.core_blocking_n_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req_o); end
    checks++; if (hits !== 32'd0) begin errors++; $display("FAIL rst_hits got %0d exp 0", hits); end
    checks++; if (misses !== 32'd0) begin errors++; $display("FAIL rst_misses got %0d exp 0", misses); end
    checks++; if (bus.core_data_o !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.core_data_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_miss_fill();
    access(30'h40, 4'b0000, 32'h0, 32'hDEADBEEF, 3, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL miss_timeout got %b exp 0", tmo); end
    checks++; if (low !== 4) begin errors++; $display("FAIL miss_low_cycles got %0d exp 4", low); end
    checks++; if (mc !== 3) begin errors++; $display("FAIL miss_mem_cycles got %0d exp 3", mc); end
    checks++; if (sw !== 1'b0 || sa !== 30'h40) begin errors++; $display("FAIL miss_mem_cmd got we=%b addr=%h exp we=0 addr=40", sw, sa); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got %h exp deadbeef", rd); end
    checks++; if (misses !== 32'd1) begin errors++; $display("FAIL miss_count got %0d exp 1", misses); end
  endtask

  task automatic test_hit();
    access(30'h40, 4'b0000, 32'h0, 32'h0, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 0 || mc !== 0) begin errors++; $display("FAIL hit_latency got low=%0d mem=%0d exp 0 0", low, mc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data got %h exp deadbeef", rd); end
    checks++; if (hits !== 32'd1 || misses !== 32'd1) begin errors++; $display("FAIL hit_counts got h=%0d m=%0d exp 1 1", hits, misses); end
  endtask

  task automatic test_store_merge();
    access(30'h40, 4'b0010, 32'h0000AA00, 32'h0, 2, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 3 || mc !== 2) begin errors++; $display("FAIL store_cycles got low=%0d mem=%0d exp 3 2", low, mc); end
    checks++; if (sw !== 1'b1 || ss !== 4'b0010 || sa !== 30'h40) begin errors++; $display("FAIL store_mem_cmd got we=%b strb=%b addr=%h exp 1 0010 40", sw, ss, sa); end
    access(30'h40, 4'b0000, 32'h0, 32'h0, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 0 || rd !== 32'hDEADAAEF) begin errors++; $display("FAIL store_merge got low=%0d data=%h exp 0 deadaaef", low, rd); end
    checks++; if (hits !== 32'd2 || misses !== 32'd1) begin errors++; $display("FAIL store_counts got h=%0d m=%0d exp 2 1", hits, misses); end
  endtask

  task automatic test_alias();
    access(30'h50, 4'b0000, 32'h0, 32'h12345678, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || rd !== 32'h12345678) begin errors++; $display("FAIL alias_fill got low=%0d data=%h exp 2 12345678", low, rd); end
    access(30'h40, 4'b0000, 32'h0, 32'hDEADAAEF, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || rd !== 32'hDEADAAEF) begin errors++; $display("FAIL alias_evict got low=%0d data=%h exp 2 deadaaef", low, rd); end
    checks++; if (misses !== 32'd3) begin errors++; $display("FAIL alias_misses got %0d exp 3", misses); end
  endtask

  task automatic test_store_no_alloc();
    access(30'h41, 4'b1111, 32'h11111111, 32'h0, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    access(30'h41, 4'b0000, 32'h0, 32'h0BADF00D, 2, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 3 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL no_alloc got low=%0d data=%h exp 3 0badf00d", low, rd); end
    checks++; if (misses !== 32'd4) begin errors++; $display("FAIL no_alloc_misses got %0d exp 4", misses); end
  endtask

  task automatic test_invalidate();
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    checks++; if (bus.core_blocking_n_o !== 1'b1 || hits !== 32'd2 || misses !== 32'd4) begin errors++; $display("FAIL idle_hold got blk=%b h=%0d m=%0d exp 1 2 4", bus.core_blocking_n_o, hits, misses); end
    access(30'h40, 4'b0000, 32'h0, 32'hDEADAAEF, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || misses !== 32'd5) begin errors++; $display("FAIL inv_reload got low=%0d m=%0d exp 2 5", low, misses); end
    access(30'h42, 4'b0000, 32'h0, 32'h22224444, 3, 2, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 4 || rd !== 32'h22224444) begin errors++; $display("FAIL inv_busy_fill got low=%0d data=%h exp 4 22224444", low, rd); end
    access(30'h42, 4'b0000, 32'h0, 32'h0, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 0 || rd !== 32'h22224444) begin errors++; $display("FAIL inv_busy_ignored got low=%0d data=%h exp 0 22224444", low, rd); end
    access(30'h40, 4'b0000, 32'h0, 32'h0, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 0 || hits !== 32'd4 || misses !== 32'd6) begin errors++; $display("FAIL inv_busy_counts got low=%0d h=%0d m=%0d exp 0 4 6", low, hits, misses); end
    access(30'h40, 4'b0000, 32'h0, 32'hDEADAAEF, 1, 1, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || misses !== 32'd7) begin errors++; $display("FAIL inv_same_cycle got low=%0d m=%0d exp 2 7", low, misses); end
    access(30'h42, 4'b0000, 32'h0, 32'h22224444, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || misses !== 32'd8) begin errors++; $display("FAIL inv_all_lines got low=%0d m=%0d exp 2 8", low, misses); end
  endtask

  task automatic test_reset_mid_miss();
    bus.core_enabled_i  = 1'b1;
    bus.core_address_i  = 30'h43;
    bus.core_write_en_i = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL mid_miss_req got %b exp 1", bus.mem_req_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0 || bus.core_blocking_n_o !== 1'b1) begin errors++; $display("FAIL async_rst got req=%b blk=%b exp 0 1", bus.mem_req_o, bus.core_blocking_n_o); end
    checks++; if (hits !== 32'd0 || misses !== 32'd0 || bus.core_data_o !== 32'd0) begin errors++; $display("FAIL async_rst_state got h=%0d m=%0d d=%h exp 0 0 0", hits, misses, bus.core_data_o); end
    bus.core_enabled_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(30'h43, 4'b0000, 32'h0, 32'h33335555, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || rd !== 32'h33335555 || misses !== 32'd1) begin errors++; $display("FAIL post_rst_miss got low=%0d data=%h m=%0d exp 2 33335555 1", low, rd, misses); end
    access(30'h40, 4'b0000, 32'h0, 32'hDEADAAEF, 1, 0, low, mc, rd, sw, ss, sa, tmo);
    checks++; if (low !== 2 || misses !== 32'd2 || hits !== 32'd0) begin errors++; $display("FAIL post_rst_valid got low=%0d m=%0d h=%0d exp 2 2 0", low, misses, hits); end
  endtask

  initial begin
    bus.core_enabled_i  = 1'b0;
    bus.core_address_i  = '0;
    bus.core_write_en_i = '0;
    bus.core_data_i     = '0;
    bus.mem_rdata_i     = '0;
    bus.mem_ack_i       = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_miss_fill();
    test_hit();
    test_store_merge();
    test_alias();
    test_store_no_alloc();
    test_invalidate();
    test_reset_mid_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 16, number of one-word direct-mapped lines; power of two, at least 2.
REQ-002 Parameter IDX_W, default $clog2(LINES), index width.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-low.
REQ-005 core_enabled_i  in  1  core request valid.
REQ-006 core_address_i  in  30  word address [31:2].
REQ-007 core_write_en_i  in  4  byte strobes; nonzero means store, zero means load.
REQ-008 core_data_i  in  32  store data.
REQ-009 core_data_o  out  32  load data.
REQ-010 core_blocking_n_o  out  1  0 means busy, core holds request stable.
REQ-011 invalidate_i  in  1  clear all valid bits.
REQ-012 mem_req_o  out  1  backing-memory request.
REQ-013 mem_we_o  out  1  memory write.
REQ-014 mem_addr_o  out  30  memory word address.
REQ-015 mem_wdata_o  out  32  memory write data.
REQ-016 mem_wstrb_o  out  4  memory byte strobes.
REQ-017 mem_rdata_i  in  32  memory read data.
REQ-018 mem_ack_i  in  1  memory completion, one-cycle pulse.
REQ-019 hit_count_o  out  32  count of load hits.
REQ-020 miss_count_o  out  32  count of load misses.

Function
REQ-021 Storage per line: valid bit, tag = address[31:IDX_W+2], 32-bit data; index = address[IDX_W+1:2].
REQ-022 FSM states: IDLE, RD_MISS, WR_THRU, DONE.
REQ-023 Request accepted when core_enabled_i=1 and core_blocking_n_o=1; core presents next request in the following cycle.
REQ-024 IDLE load hit: core_blocking_n_o=1 and core_data_o=line data combinationally in the same cycle; zero-cycle latency; hit_count_o increments.
REQ-025 IDLE load miss: core_blocking_n_o=0 combinationally in the same cycle; next state RD_MISS; miss_count_o increments once.
REQ-026 IDLE store (hit or miss): core_blocking_n_o=0 combinationally; next state WR_THRU.
REQ-027 RD_MISS: mem_req_o=1, mem_we_o=0, mem_addr_o=core_address_i; on mem_ack_i fill line (valid=1, tag, data=mem_rdata_i), latch data, next state DONE.
REQ-028 WR_THRU: mem_req_o=1, mem_we_o=1, addr/wdata/wstrb from core; on mem_ack_i, if hit, merge strobed bytes into line; a miss does not allocate; next state DONE.
REQ-029 mem_* outputs stable while mem_req_o=1 until mem_ack_i; mem_ack_i is ignored in IDLE and DONE.
REQ-030 DONE: core_blocking_n_o=1; core_data_o=latched fill data (store: don't-care); completes the held request without re-evaluation; unconditional return to IDLE.
REQ-031 core_blocking_n_o=0 in RD_MISS and WR_THRU regardless of mem_ack_i.
REQ-032 core_enabled_i=0 in IDLE: core_blocking_n_o=1, no state change, counters hold.
REQ-033 invalidate_i honored only in IDLE; clears all valid bits at the edge; a same-cycle load sees a miss.
REQ-034 If invalidate_i is asserted outside IDLE, it is ignored.
REQ-035 Counters wrap from 0xFFFFFFFF to 0.
REQ-036 Outside RD_MISS and WR_THRU, mem_req_o=0.

Reset
REQ-037 While rst_i=0: state=IDLE, all valid bits=0, mem_req_o=0, hit_count_o=0, miss_count_o=0, core_blocking_n_o=1, core_data_o=0 (latched data cleared).
REQ-038 Reset asserted mid-miss abandons the memory transaction: mem_req_o drops asynchronously; no line is filled.
REQ-039 Line data need not be reset.

Verification
REQ-040 After reset, load 0x100>>2 with mem_rdata_i=0xDEADBEEF and ack after 3 cycles -> blocking_n low 4 cycles, DONE returns 0xDEADBEEF, miss_count_o=1.
REQ-041 Repeat the same load -> zero-latency hit, data 0xDEADBEEF, hit_count_o=1, mem_req_o stays 0.
REQ-042 Store strobe 4'b0010, data 0x0000AA00 to the same address -> one memory write with wstrb 0010; subsequent hit returns 0xDEADAAEF.
REQ-043 Load to an address aliasing index 0 with a different tag -> miss, line replaced; original address then misses again.
REQ-044 invalidate_i pulse in IDLE, then reload -> miss; invalidate_i during RD_MISS -> ignored, fill completes.
REQ-045 rst_i low during RD_MISS before ack -> mem_req_o=0 immediately, counters 0; after release the same load misses.
